// File: rtl/cfg_pkg.sv
`timescale 1ns/1ps
// Shared configuration-chain types and default chain geometry (also used by the io_bank top).
package cfg_pkg;

    localparam int unsigned CHAIN_LEN_DEF = 64;
    localparam int unsigned WORD_W_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } cfg_state_e;

endpackage

// File: rtl/cfg_serdes.sv
`timescale 1ns/1ps
// Word serialiser / readback deserialiser for the configuration chain.
// Holds the outgoing shift register, the captured tail bits and the in-word bit index.
module cfg_serdes #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned NB_W   = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic              clear,
    input  logic [WORD_W-1:0] load_data,
    input  logic [NB_W-1:0]   load_nbits,
    input  logic              ret_in,
    output logic              bit_out,
    output logic              last_c,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
);

    localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] rbreg;
    logic [WORD_W-1:0] sh_nxt_c;
    logic [WORD_W-1:0] rb_nxt_c;
    logic [IDX_W-1:0]  idx;
    logic [NB_W-1:0]   nbits;

    // Next shift/capture values; the tail bit lands at the current in-word index.
    always_comb begin
        sh_nxt_c      = shreg >> 1;
        rb_nxt_c      = rbreg;
        rb_nxt_c[idx] = ret_in;
        last_c        = (32'(idx) + 32'd1) == 32'(nbits);
    end

    // bit_out is registered so chain_data never depends combinationally on inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            rbreg    <= '0;
            idx      <= '0;
            nbits    <= '0;
            bit_out  <= 1'b0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (clear) begin
                bit_out <= 1'b0;
                idx     <= '0;
            end else if (load) begin
                shreg   <= load_data;
                rbreg   <= '0;
                nbits   <= load_nbits;
                idx     <= '0;
                bit_out <= load_data[0];
            end else if (shift) begin
                shreg   <= sh_nxt_c;
                rbreg   <= rb_nxt_c;
                idx     <= idx + IDX_W'(1);
                bit_out <= last_c ? 1'b0 : sh_nxt_c[0];
                if (last_c) begin
                    rb_data  <= rb_nxt_c;
                    rb_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cfg_chain_loader.sv
`timescale 1ns/1ps
// Configuration chain loader: streams host words LSB-first into the fabric chain
// for exactly CHAIN_LEN bits and returns the displaced tail bits as readback words.
module cfg_chain_loader
    import cfg_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEF,
    parameter int unsigned WORD_W    = WORD_W_DEF
) (
    input  logic              prog_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    output logic              busy,
    output logic              done,
    output logic              chain_en,
    output logic              chain_data,
    input  logic              chain_ret
);

    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned NB_W  = $clog2(WORD_W + 1);

    cfg_state_e       state;
    cfg_state_e       state_n;
    logic [CNT_W-1:0] bitcnt;
    logic [CNT_W-1:0] remain_c;
    logic [NB_W-1:0]  nbits_c;
    logic             load_c;
    logic             shift_c;
    logic             cnt_clr_c;
    logic             cnt_inc_c;
    logic             last_c;

    // Bits in the next word: a full word, or whatever is left of the chain.
    always_comb begin
        remain_c = CNT_W'(CHAIN_LEN) - bitcnt;
        nbits_c  = (32'(remain_c) < WORD_W) ? NB_W'(remain_c) : NB_W'(WORD_W);
    end

    // Next-state and strobe decode; abort overrides everything.
    always_comb begin
        state_n   = state;
        load_c    = 1'b0;
        shift_c   = 1'b0;
        cnt_clr_c = 1'b0;
        cnt_inc_c = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n   = LOAD;
                    cnt_clr_c = 1'b1;
                end
            end
            LOAD: begin
                if (cfg_valid && cfg_ready) begin
                    load_c  = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                shift_c   = 1'b1;
                cnt_inc_c = 1'b1;
                if (last_c) begin
                    state_n = ((32'(bitcnt) + 32'd1) == CHAIN_LEN) ? DONE : LOAD;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (abort) begin
            state_n   = IDLE;
            load_c    = 1'b0;
            shift_c   = 1'b0;
            cnt_inc_c = 1'b0;
            cnt_clr_c = 1'b1;
        end
    end

    // State register; status outputs are registered decodes of the next state.
    always_ff @(posedge prog_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bitcnt    <= '0;
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            chain_en  <= 1'b0;
        end else begin
            state     <= state_n;
            cfg_ready <= (state_n == LOAD);
            busy      <= (state_n != IDLE);
            done      <= (state_n == DONE);
            chain_en  <= (state_n == SHIFT);
            if (cnt_clr_c) begin
                bitcnt <= '0;
            end else if (cnt_inc_c) begin
                bitcnt <= bitcnt + CNT_W'(1);
            end
        end
    end

    cfg_serdes #(
        .WORD_W (WORD_W),
        .NB_W   (NB_W)
    ) u_serdes (
        .clk        (prog_clk),
        .rst_n      (rst_n),
        .load       (load_c),
        .shift      (shift_c),
        .clear      (abort),
        .load_data  (cfg_data),
        .load_nbits (nbits_c),
        .ret_in     (chain_ret),
        .bit_out    (chain_data),
        .last_c     (last_c),
        .rb_data    (rb_data),
        .rb_valid   (rb_valid)
    );

endmodule
